datapath: RTL and testbench
===========================

Name: datapath

Overview:
- Datapath slave of the control unit `cu`. It receives `WE`, `CUconst`, `InMuxAdd`, `RegAdd`, `OutMuxAdd` and `InsSel` from the control unit.
- It returns status `Busy`, `C0` and `Z`.
- It holds a 16x8 register file, a single-cycle ALU (ADD/SUB/AND) and an 8-cycle shift-add multiplier with a product-high register `PH`.
- `DataIn` is the external byte input. `DataOut` is the observed result.

Parameters:
- WIDTH, 8, datapath word width. Only 8 is supported; the multiplier counter and the `CUconst` width depend on it.
- NREG, 16, number of registers; address width 4.
- MUL_CYC, 8, multiplier iterations; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- WE  in  1  write enable for the current command
- CUconst  in  8  immediate constant from the control unit
- InMuxAdd  in  3  write-source select
- RegAdd  in  4  destination register; also ALU operand B
- OutMuxAdd  in  4  source register; ALU operand A; `DataOut` select
- InsSel  in  2  ALU operation
- DataIn  in  8  external data byte
- DataOut  out  8  R[OutMuxAdd], combinational read
- Busy  out  1  multiplier in progress
- C0  out  1  carry/borrow/overflow flag
- Z  out  1  zero flag

Behaviour:
- Reset (sync, `rst`=1 at rising edge): R0..R15=0, PH=0, Busy=0, C0=0, Z=0, mul counter=0. Reset overrides any in-flight command, including mid-multiply (abort, no write).
- Operands: A=R[OutMuxAdd], B=R[RegAdd], both read combinationally.
- `InsSel` encoding:
  - 00 ADD: B+A, C0=carry-out.
  - 01 SUB: B-A, C0=borrow (1 when B<A).
  - 10 AND: B&A, C0=0.
  - 11 MUL: multi-cycle.
- `InMuxAdd` encoding (with WE=1, Busy=0, write R[RegAdd] at the edge):
  - 000: CUconst
  - 001: DataIn
  - 010: ALU result
  - 011: R[OutMuxAdd] (move)
  - 100: PH
  - 101-111: reserved, no write, flags unchanged.
- Flag update:
  - C0 and Z update only on InMuxAdd=010 with InsSel!=11, from the 8-bit result (Z = result==0).
  - All other writes leave flags unchanged.
- Single-cycle latency: written value visible on `DataOut` and in flags the cycle after the write edge.
- Same-cycle read of the destination register returns the old value.
- MUL issue:
  - Condition: WE=1, InMuxAdd=010, InsSel=11, Busy=0, at edge E0.
  - Captures A, B and RegAdd into internal registers.
  - Sets Busy=1 and counter=0. No write at E0.
- MUL iterations:
  - Edges E1..E8 each perform one shift-add step.
  - At E8: R[captured RegAdd]=product[7:0], PH=product[15:8], Z=(product==0), C0=(product[15:8]!=0), Busy=0.
  - Busy is therefore high for exactly 8 cycles. The result is visible in the cycle after E8.
- While Busy=1:
  - All commands (WE) are ignored; no register, PH or flag change except the multiplier's own E8 write.
  - Inputs may change freely.
- State machine: IDLE -> (MUL issue) -> MULT (counter 0..7) -> IDLE at the E8 write. Any other value of the state register -> IDLE.
- Arithmetic is unsigned, modulo 2^8. The product is a full 16-bit result.

Decomposition:
- Shared package `cu_pkg`, used by both `cu` and `datapath`:
  - InsSel codes: OP_ADD, OP_SUB, OP_AND, OP_MUL.
  - InMuxAdd codes: SRC_CONST, SRC_IN, SRC_ALU, SRC_MOV, SRC_PH.
  - WIDTH.
- One sub-module, `mul_shift_add8`:
  - Inputs: clk, rst, start, a, b.
  - Outputs: busy, done pulse, 16-bit product.
  - The datapath performs the E8 write on `done`.

Test Plan:
- Reset -> with rst=1 for 2 cycles, then: `DataOut`=0x00 for every OutMuxAdd, Busy=0, C0=0, Z=0, PH=0.
- ADD carry:
  - Load CUconst 0xC8 into R1 and 0x64 into R2 (InMuxAdd=000).
  - ADD with OutMuxAdd=1, RegAdd=2 -> R2=0x2C, C0=1, Z=0.
  - DataIn 0x7F into R7 (InMuxAdd=001) -> R7=0x7F, flags unchanged.
- SUB zero/borrow:
  - R3=0x10, R4=0x10; SUB with Out=3, Reg=4 -> R4=0x00, Z=1, C0=0.
  - Then SUB with Out=1, Reg=4 -> R4=0x38, C0=1, Z=0.
- MUL:
  - R5=0x0F, R6=0x11; MUL with Out=5, Reg=6 -> Busy high for exactly 8 cycles, then R6=0xFF, PH=0x00, C0=0, Z=0.
  - 0xFF*0xFF -> low byte 0x01, PH=0xFE (read via InMuxAdd=100), C0=1.
- Ignore while busy:
  - Pulse WE with CUconst 0xAA to R9 at busy cycle 3 -> R9 unchanged.
  - Issue reserved InMuxAdd=101 with WE -> no register or flag change.
- Reset mid-multiply: assert rst at busy cycle 4 -> next cycle Busy=0, destination register 0, PH=0, and no late E8 write occurs.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings between the control unit and the datapath.
package cu_pkg;

  localparam int unsigned WIDTH = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_MUL = 2'b11
  } ins_sel_t;

  typedef enum logic [2:0] {
    SRC_CONST = 3'b000,
    SRC_IN    = 3'b001,
    SRC_ALU   = 3'b010,
    SRC_MOV   = 3'b011,
    SRC_PH    = 3'b100
  } src_sel_t;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_RUN  = 2'b01
  } mul_state_t;

  // ALU result with carry/borrow in the top bit.
  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] value;
  } alu_t;

endpackage

// File: rtl/mul_shift_add8.sv
// Unsigned shift-add multiplier, one partial product per cycle.
// done_c/product_c are asserted combinationally on the final step edge.
module mul_shift_add8
  import cu_pkg::*;
#(
  parameter int unsigned STEPS = WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done_c,
  output logic [2*WIDTH-1:0] product_c
);

  localparam int unsigned CW = $clog2(STEPS);
  localparam int unsigned PW = 2 * WIDTH;

  mul_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]  acc_q, acc_d;
  logic [PW-1:0]  step_acc;

  assign busy = (state_q == MUL_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MUL_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Next state plus one accumulate step per cycle while running.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    done_c    = 1'b0;
    step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
    product_c = acc_q;
    case (state_q)
      MUL_IDLE: begin
        if (start) begin
          state_d  = MUL_RUN;
          cnt_d    = '0;
          mcand_d  = PW'(a);
          mplier_d = b;
          acc_d    = '0;
        end
      end
      MUL_RUN: begin
        acc_d    = step_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) begin
          state_d   = MUL_IDLE;
          cnt_d     = '0;
          done_c    = 1'b1;
          product_c = step_acc;
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Register file, single-cycle ALU and multi-cycle multiplier driven by the cu.
// Commands are ignored while the multiplier runs; it writes its own result.
module datapath
  import cu_pkg::*;
#(
  parameter int unsigned NREG    = 16,
  parameter int unsigned MUL_CYC = WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    WE,
  input  logic [WIDTH-1:0]        CUconst,
  input  logic [2:0]              InMuxAdd,
  input  logic [$clog2(NREG)-1:0] RegAdd,
  input  logic [$clog2(NREG)-1:0] OutMuxAdd,
  input  logic [1:0]              InsSel,
  input  logic [WIDTH-1:0]        DataIn,
  output logic [WIDTH-1:0]        DataOut,
  output logic                    Busy,
  output logic                    C0,
  output logic                    Z
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] rf [NREG];
  logic [WIDTH-1:0] ph_q;
  logic             c0_q, z_q;
  logic [AW-1:0]    dst_q;

  logic [WIDTH-1:0] opa_c, opb_c;
  alu_t             alu_c;
  logic             accept_c, mul_start_c;
  logic             mul_busy, mul_done_c;
  logic [PW-1:0]    mul_prod_c;

  assign opa_c   = rf[OutMuxAdd];
  assign opb_c   = rf[RegAdd];
  assign DataOut = opa_c;
  assign Busy    = mul_busy;
  assign C0      = c0_q;
  assign Z       = z_q;

  assign accept_c    = WE && !mul_busy;
  assign mul_start_c = accept_c && (InMuxAdd == SRC_ALU) && (InsSel == OP_MUL);

  // Single-cycle ALU: result = B op A.
  always_comb begin
    alu_c = '0;
    case (ins_sel_t'(InsSel))
      OP_ADD:  alu_c = alu_t'((WIDTH+1)'(opb_c) + (WIDTH+1)'(opa_c));
      OP_SUB:  alu_c = alu_t'((WIDTH+1)'(opb_c) - (WIDTH+1)'(opa_c));
      OP_AND:  alu_c.value = opb_c & opa_c;
      default: alu_c = '0;
    endcase
  end

  mul_shift_add8 #(
    .STEPS(MUL_CYC)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start    (mul_start_c),
    .a        (opa_c),
    .b        (opb_c),
    .busy     (mul_busy),
    .done_c   (mul_done_c),
    .product_c(mul_prod_c)
  );

  // Register file, PH and flags; the multiplier's final edge has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
      ph_q  <= '0;
      c0_q  <= 1'b0;
      z_q   <= 1'b0;
      dst_q <= '0;
    end else if (mul_done_c) begin
      rf[dst_q] <= mul_prod_c[WIDTH-1:0];
      ph_q      <= mul_prod_c[PW-1:WIDTH];
      z_q       <= (mul_prod_c == '0);
      c0_q      <= |mul_prod_c[PW-1:WIDTH];
    end else if (accept_c) begin
      case (src_sel_t'(InMuxAdd))
        SRC_CONST: rf[RegAdd] <= CUconst;
        SRC_IN:    rf[RegAdd] <= DataIn;
        SRC_ALU: begin
          if (InsSel != OP_MUL) begin
            rf[RegAdd] <= alu_c.value;
            c0_q       <= alu_c.carry;
            z_q        <= (alu_c.value == '0);
          end else begin
            dst_q <= RegAdd;
          end
        end
        SRC_MOV:   rf[RegAdd] <= opa_c;
        SRC_PH:    rf[RegAdd] <= ph_q;
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: directed table, multi-cycle sequences
// and random commands against a behavioural model.
`timescale 1ns/1ps
module tb_datapath;

  logic       clk;
  logic       rst;
  logic       WE;
  logic [7:0] CUconst;
  logic [2:0] InMuxAdd;
  logic [3:0] RegAdd;
  logic [3:0] OutMuxAdd;
  logic [1:0] InsSel;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       Busy;
  logic       C0;
  logic       Z;

  datapath dut (
    .clk      (clk),
    .rst      (rst),
    .WE       (WE),
    .CUconst  (CUconst),
    .InMuxAdd (InMuxAdd),
    .RegAdd   (RegAdd),
    .OutMuxAdd(OutMuxAdd),
    .InsSel   (InsSel),
    .DataIn   (DataIn),
    .DataOut  (DataOut),
    .Busy     (Busy),
    .C0       (C0),
    .Z        (Z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model state.
  logic [7:0]  m_r [16];
  logic [7:0]  m_ph;
  logic        m_c0, m_z;
  int          m_busy;
  logic [15:0] m_prod;
  logic [3:0]  m_dst;

  typedef struct {
    logic       we;
    logic [2:0] src;
    logic [1:0] sel;
    logic [3:0] ra;
    logic [3:0] oa;
    logic [7:0] k;
    logic [7:0] din;
    logic [3:0] ca;
    logic [7:0] ev;
    logic       ec0;
    logic       ez;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic void model_edge();
    logic [7:0] a, b;
    logic [8:0] s;
    a = m_r[OutMuxAdd];
    b = m_r[RegAdd];
    if (rst) begin
      foreach (m_r[i]) m_r[i] = 8'h00;
      m_ph = 8'h00; m_c0 = 1'b0; m_z = 1'b0; m_busy = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_r[m_dst] = m_prod[7:0];
        m_ph = m_prod[15:8];
        m_z  = (m_prod == 16'h0000);
        m_c0 = (m_prod[15:8] != 8'h00);
      end
    end else if (WE) begin
      case (InMuxAdd)
        3'd0: m_r[RegAdd] = CUconst;
        3'd1: m_r[RegAdd] = DataIn;
        3'd2: begin
          case (InsSel)
            2'd0: begin s = {1'b0, b} + {1'b0, a}; m_r[RegAdd] = s[7:0]; m_c0 = s[8]; end
            2'd1: begin m_r[RegAdd] = b - a; m_c0 = (b < a); end
            2'd2: begin m_r[RegAdd] = b & a; m_c0 = 1'b0; end
            default: begin m_prod = 16'(a) * 16'(b); m_dst = RegAdd; m_busy = 8; end
          endcase
          if (InsSel != 2'd3) m_z = (m_r[RegAdd] == 8'h00);
        end
        3'd3: m_r[RegAdd] = a;
        3'd4: m_r[RegAdd] = m_ph;
        default: ;
      endcase
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    OutMuxAdd = a;
    #0.1;
    v = DataOut;
  endtask

  task automatic idle_inputs();
    WE = 1'b0; CUconst = 8'h00; InMuxAdd = 3'd0; RegAdd = 4'd0;
    OutMuxAdd = 4'd0; InsSel = 2'd0; DataIn = 8'h00;
  endtask

  task automatic ph_to(input logic [3:0] r);
    WE = 1'b1; InMuxAdd = 3'd4; RegAdd = r;
    step();
    WE = 1'b0;
  endtask

  // kind: 0 none, 1 write 0xAA to R9 at busy cycle act_at, 2 reset at busy cycle act_at
  task automatic run_mul(input logic [3:0] oa, input logic [3:0] ra,
                         input int act_at, input int kind, output int nbusy);
    WE = 1'b1; InMuxAdd = 3'd2; InsSel = 2'd3; OutMuxAdd = oa; RegAdd = ra;
    step();
    WE = 1'b0;
    nbusy = 0;
    while (Busy === 1'b1 && nbusy < 20) begin
      nbusy++;
      OutMuxAdd = 4'($urandom_range(0, 15));
      if (nbusy == act_at && kind == 1) begin
        WE = 1'b1; InMuxAdd = 3'd0; CUconst = 8'hAA; RegAdd = 4'd9; InsSel = 2'd0;
      end else if (nbusy == act_at && kind == 2) begin
        rst = 1'b1;
      end
      step();
      WE = 1'b0; rst = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] v;
    int nb;

    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      chk($sformatf("reset_R%0d", i), 16'(v), 16'h0000);
    end
    chk("reset_busy", 16'(Busy), 16'h0000);
    chk("reset_c0", 16'(C0), 16'h0000);
    chk("reset_z", 16'(Z), 16'h0000);

    //            we    src   sel   ra    oa    k      din    ca    ev     c0    z
    tbl[0]  = '{1'b1, 3'd4, 2'd0, 4'd0, 4'd0, 8'h00, 8'h00, 4'd0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 3'd0, 2'd0, 4'd1, 4'd0, 8'hC8, 8'h00, 4'd1, 8'hC8, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 3'd0, 2'd0, 4'd2, 4'd0, 8'h64, 8'h00, 4'd2, 8'h64, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 3'd2, 2'd0, 4'd2, 4'd1, 8'h00, 8'h00, 4'd2, 8'h2C, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 3'd1, 2'd0, 4'd7, 4'd0, 8'h00, 8'h7F, 4'd7, 8'h7F, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 3'd0, 2'd0, 4'd3, 4'd0, 8'h10, 8'h00, 4'd3, 8'h10, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 3'd0, 2'd0, 4'd4, 4'd0, 8'h10, 8'h00, 4'd4, 8'h10, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 3'd2, 2'd1, 4'd4, 4'd3, 8'h00, 8'h00, 4'd4, 8'h00, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 3'd2, 2'd1, 4'd4, 4'd1, 8'h00, 8'h00, 4'd4, 8'h38, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 3'd2, 2'd2, 4'd2, 4'd1, 8'h00, 8'h00, 4'd2, 8'h08, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 3'd3, 2'd0, 4'd8, 4'd7, 8'h00, 8'h00, 4'd8, 8'h7F, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 3'd5, 2'd0, 4'd8, 4'd0, 8'h55, 8'h55, 4'd8, 8'h7F, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 3'd4, 2'd0, 4'd10, 4'd0, 8'h00, 8'h00, 4'd10, 8'h00, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 3'd0, 2'd0, 4'd5, 4'd0, 8'h0F, 8'h00, 4'd5, 8'h0F, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 3'd0, 2'd0, 4'd6, 4'd0, 8'h11, 8'h00, 4'd6, 8'h11, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 3'd0, 2'd0, 4'd5, 4'd0, 8'hEE, 8'h00, 4'd5, 8'h0F, 1'b0, 1'b0};

    foreach (tbl[i]) begin
      WE = tbl[i].we; InMuxAdd = tbl[i].src; InsSel = tbl[i].sel;
      RegAdd = tbl[i].ra; OutMuxAdd = tbl[i].oa; CUconst = tbl[i].k; DataIn = tbl[i].din;
      step();
      WE = 1'b0;
      rd(tbl[i].ca, v);
      chk($sformatf("vec%0d_data", i), 16'(v), 16'(tbl[i].ev));
      chk($sformatf("vec%0d_c0", i), 16'(C0), 16'(tbl[i].ec0));
      chk($sformatf("vec%0d_z", i), 16'(Z), 16'(tbl[i].ez));
    end

    // Same-cycle read of the destination returns the old value.
    WE = 1'b1; InMuxAdd = 3'd0; CUconst = 8'h33; RegAdd = 4'd3; OutMuxAdd = 4'd3;
    #0.1;
    chk("same_cycle_old", 16'(DataOut), 16'h0010);
    step();
    WE = 1'b0;
    chk("same_cycle_new", 16'(DataOut), 16'h0033);

    // 0x0F * 0x11 with an ignored write during busy cycle 3.
    run_mul(4'd5, 4'd6, 3, 1, nb);
    chk("mul1_busy_cycles", 16'(nb), 16'd8);
    rd(4'd6, v);
    chk("mul1_lo", 16'(v), 16'h00FF);
    chk("mul1_c0", 16'(C0), 16'h0000);
    chk("mul1_z", 16'(Z), 16'h0000);
    rd(4'd9, v);
    chk("busy_ignore_R9", 16'(v), 16'h0000);
    ph_to(4'd11);
    rd(4'd11, v);
    chk("mul1_ph", 16'(v), 16'h0000);

    // 0xFF * 0xFF.
    WE = 1'b1; InMuxAdd = 3'd0; CUconst = 8'hFF; RegAdd = 4'd12;
    step();
    run_mul(4'd12, 4'd12, 0, 0, nb);
    chk("mul2_busy_cycles", 16'(nb), 16'd8);
    rd(4'd12, v);
    chk("mul2_lo", 16'(v), 16'h0001);
    chk("mul2_c0", 16'(C0), 16'h0001);
    chk("mul2_z", 16'(Z), 16'h0000);
    ph_to(4'd13);
    rd(4'd13, v);
    chk("mul2_ph", 16'(v), 16'h00FE);

    // Reset at busy cycle 4 aborts the multiply.
    run_mul(4'd5, 4'd6, 4, 2, nb);
    chk("rstmul_busy_cycles", 16'(nb), 16'd4);
    chk("rstmul_busy", 16'(Busy), 16'h0000);
    rd(4'd6, v);
    chk("rstmul_dst", 16'(v), 16'h0000);
    ph_to(4'd14);
    rd(4'd14, v);
    chk("rstmul_ph", 16'(v), 16'h0000);
    for (int i = 0; i < 10; i++) step();
    chk("rstmul_late_busy", 16'(Busy), 16'h0000);
    rd(4'd6, v);
    chk("rstmul_late_dst", 16'(v), 16'h0000);
    chk("rstmul_late_z", 16'(Z), 16'h0000);

    // Random commands against the model.
    for (int c = 0; c < 500; c++) begin
      rst       = ($urandom_range(0, 119) == 0);
      WE        = 1'($urandom_range(0, 1));
      CUconst   = 8'($urandom);
      DataIn    = 8'($urandom);
      InMuxAdd  = ($urandom_range(0, 2) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
      InsSel    = 2'($urandom_range(0, 3));
      RegAdd    = 4'($urandom_range(0, 15));
      OutMuxAdd = 4'($urandom_range(0, 15));
      step();
      rst = 1'b0;
      chk($sformatf("rnd%0d_data", c), 16'(DataOut), 16'(m_r[OutMuxAdd]));
      chk($sformatf("rnd%0d_busy", c), 16'(Busy), 16'(m_busy != 0));
      chk($sformatf("rnd%0d_c0", c), 16'(C0), 16'(m_c0));
      chk($sformatf("rnd%0d_z", c), 16'(Z), 16'(m_z));
    end
    WE = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), v);
      chk($sformatf("scan_R%0d", i), 16'(v), 16'(m_r[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
